adrv9001_enable_seq: RTL and testbench
======================================

ADRV9001_ENABLE_SEQ -- requirements
Module: adrv9001_enable_seq

Interface
REQ-001 SHALL have parameter DLY_W, default 16, width of all delay inputs and timers.
REQ-002 SHALL have parameter CNT_W, default 16, width of enable_cnt/disable_cnt.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable_mode  in  1  enable source select: 0 = sw_en, 1 = pl_en.
REQ-006 SHALL have ports sw_en / pl_en  in  1 each  enable requests (level).
REQ-007 SHALL have ports enable_dly / disable_dly / guard_dly  in  DLY_W each  settle, hold-off and minimum-off times in clk cycles.
REQ-008 SHALL have ports s_axis_tdata/tvalid/tlast  in  32/1/1 and s_axis_tready  out  1  upstream IQ stream.
REQ-009 SHALL have ports m_axis_tdata/tvalid/tlast  out  32/1/1 and m_axis_tready  in  1  gated stream to the interface.
REQ-010 SHALL have port adrv9001_enable  out  1  device channel enable.
REQ-011 SHALL have ports enable_cnt / disable_cnt  out  CNT_W each  rising/falling edge counts of adrv9001_enable.
REQ-012 SHALL have ports state  out  3 (current FSM encoding) and busy  out  1 (state != IDLE).

Function
REQ-013 req SHALL be registered once: req_q <= enable_mode ? pl_en : sw_en; the FSM uses only req_q.
REQ-014 FSM states SHALL be IDLE=0, SETTLE=1, ACTIVE=2, DRAIN=3, HOLD=4, GUARD=5; other encodings go to IDLE next cycle.
REQ-015 IDLE: enable=0, gate=0; req_q=1 -> SETTLE, timer<=enable_dly, adrv9001_enable<=1.
REQ-016 SETTLE: enable=1, gate=0; timer==0 -> ACTIVE, else timer-1; req_q=0 (any timer) -> HOLD with timer<=disable_dly (abort, no data passed).
REQ-017 SETTLE SHALL therefore last enable_dly+1 cycles; enable_dly=0 gives ACTIVE on the cycle after entry.
REQ-018 ACTIVE: gate=1; req_q=0 with no packet open -> HOLD, timer<=disable_dly; req_q=0 with packet open -> DRAIN.
REQ-019 Packet open SHALL mean a beat with tlast=0 has been accepted and no tlast=1 beat since; tracked by a flag cleared on reset and on tlast handshake.
REQ-020 DRAIN: gate=1 until the tlast=1 handshake; on that cycle -> HOLD, timer<=disable_dly; req_q re-assertion SHALL be ignored in DRAIN.
REQ-021 HOLD: gate=0, enable=1; timer==0 -> GUARD with adrv9001_enable<=0, timer<=guard_dly; else timer-1.
REQ-022 GUARD: enable=0; timer==0 -> IDLE, else timer-1; req_q ignored until IDLE.
REQ-023 Gating SHALL be combinational: m_axis_tvalid = s_axis_tvalid & gate; s_axis_tready = m_axis_tready & gate; tdata/tlast pass through unmodified.
REQ-024 gate SHALL be a registered signal equal to 1 exactly in ACTIVE and DRAIN.
REQ-025 enable_cnt SHALL increment on every 0->1 of adrv9001_enable, disable_cnt on every 1->0, both wrapping from all-ones to 0.
REQ-026 Delay inputs SHALL be sampled only when loaded into the timer; changes mid-count have no effect until the next load.
REQ-027 Outputs SHALL be registered except the gating terms of REQ-023.

Reset
REQ-028 rstn=0 SHALL asynchronously force state=IDLE, adrv9001_enable=0, gate=0, timer=0, req_q=0, packet flag=0, enable_cnt=0, disable_cnt=0, busy=0.
REQ-029 Reset mid-packet SHALL drop gating immediately; no recovery of the open packet is attempted.
REQ-030 After rstn release, the first req_q sample occurs on the first clk edge; SETTLE entry is one cycle later at the earliest.

Verification
REQ-031 enable_mode=1, enable_dly=4, pl_en 0->1 -> adrv9001_enable=1 two edges later, m_axis_tvalid follows s_axis_tvalid 5 cycles after that, enable_cnt=1.
REQ-032 ACTIVE, 8-beat packet, pl_en drops after beat 3 -> beats 4-8 still forwarded, HOLD entered on tlast handshake, enable falls disable_dly+1 cycles later, disable_cnt=1.
REQ-033 enable_dly=10, pl_en pulsed 3 cycles -> no beat forwarded, state SETTLE->HOLD->GUARD->IDLE, enable_cnt=disable_cnt=1.
REQ-034 guard_dly=20, request re-asserted in GUARD -> adrv9001_enable stays 0 until 21 GUARD cycles elapse, then re-enables.
REQ-035 enable_mode=0 with pl_en=1, sw_en=0 -> state stays IDLE; sw_en=1 -> sequence starts.
REQ-036 enable_cnt preloaded to 0xFFFF by 65535 cycles -> next rising enable wraps to 0x0000; rstn=0 mid-ACTIVE -> enable, gate, counters all 0 without a clock edge.

Source files
------------

// File: rtl/adrv9001_enable_seq_if.sv
// -----------------------------------------------------------------------------
// adrv9001_enable_seq_if
//   32-bit AXI-Stream style bundle used on both sides of the enable sequencer.
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid/tlast, drives tready
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface adrv9001_enable_seq_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/adrv9001_enable_seq.sv
// -----------------------------------------------------------------------------
// adrv9001_enable_seq
//   Sequences the ADRV9001 channel enable around an IQ stream. A level request
//   (software or PL, selected by enable_mode) raises the device enable, waits a
//   settle time, then opens the stream gate. When the request drops the gate
//   closes on a packet boundary, the enable is held for a hold-off time, then
//   dropped, and a minimum-off guard time is enforced before the next cycle.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   enable_mode                0 = sw_en drives the request, 1 = pl_en
//   sw_en, pl_en               level enable requests
//   enable_dly                 SETTLE length - 1, in clk cycles
//   disable_dly                HOLD length - 1, in clk cycles
//   guard_dly                  GUARD length - 1, in clk cycles
//   s_axis (slave)             upstream IQ stream
//   m_axis (master)            gated stream towards the device interface
//   adrv9001_enable            device channel enable
//   enable_cnt, disable_cnt    rising / falling edge counts of the enable
//   state                      current FSM encoding
//   busy                       high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module adrv9001_enable_seq #(
  parameter int DLY_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable_mode,
  input  logic                   sw_en,
  input  logic                   pl_en,
  input  logic [DLY_W-1:0]       enable_dly,
  input  logic [DLY_W-1:0]       disable_dly,
  input  logic [DLY_W-1:0]       guard_dly,
  adrv9001_enable_seq_if.slave   s_axis,
  adrv9001_enable_seq_if.master  m_axis,
  output logic                   adrv9001_enable,
  output logic [CNT_W-1:0]       enable_cnt,
  output logic [CNT_W-1:0]       disable_cnt,
  output logic [2:0]             state,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACTIVE = 3'd2,
    DRAIN  = 3'd3,
    HOLD   = 3'd4,
    GUARD  = 3'd5
  } state_t;

  state_t           st;
  logic             req_q;
  logic             gate;
  logic             pkt_open;
  logic             hs;
  logic             pkt_open_nxt;
  logic [DLY_W-1:0] timer;

  // Edge counters wrap naturally from all-ones back to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  function automatic logic [DLY_W-1:0] tmr_dec(input logic [DLY_W-1:0] t);
    return t - DLY_W'(1);
  endfunction

  // Gating is the only combinational path from inputs to outputs.
  assign hs              = s_axis.tvalid & m_axis.tready & gate;
  assign m_axis.tdata    = s_axis.tdata;
  assign m_axis.tlast    = s_axis.tlast;
  assign m_axis.tvalid   = s_axis.tvalid & gate;
  assign s_axis.tready   = m_axis.tready & gate;
  assign state           = st;

  // Packet state as it will be after this cycle's handshake. Using the
  // post-handshake view means a beat with tlast=0 accepted in the very cycle
  // the request is seen low still sends the FSM to DRAIN, so a packet is never
  // cut off after its first beat.
  assign pkt_open_nxt = hs ? ~s_axis.tlast : pkt_open;

  // Request sample stage: the FSM never looks at sw_en/pl_en directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q    <= 1'b0;
      pkt_open <= 1'b0;
    end else begin
      req_q    <= enable_mode ? pl_en : sw_en;
      pkt_open <= pkt_open_nxt;
    end
  end

  // Sequencer stage: all outputs are registered here alongside the state.
  // Delay inputs are only read at the moment they are loaded into timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st              <= IDLE;
      gate            <= 1'b0;
      timer           <= '0;
      adrv9001_enable <= 1'b0;
      enable_cnt      <= '0;
      disable_cnt     <= '0;
      busy            <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (req_q) begin
            st              <= SETTLE;
            busy            <= 1'b1;
            timer           <= enable_dly;
            adrv9001_enable <= 1'b1;
            enable_cnt      <= cnt_inc(enable_cnt);
          end
        end

        SETTLE: begin
          // A dropped request aborts settling regardless of the timer.
          if (!req_q) begin
            st    <= HOLD;
            timer <= disable_dly;
          end else if (timer == '0) begin
            st   <= ACTIVE;
            gate <= 1'b1;
          end else begin
            timer <= tmr_dec(timer);
          end
        end

        ACTIVE: begin
          if (!req_q) begin
            if (pkt_open_nxt) begin
              st <= DRAIN;
            end else begin
              st    <= HOLD;
              gate  <= 1'b0;
              timer <= disable_dly;
            end
          end
        end

        DRAIN: begin
          // Request re-assertion is deliberately ignored until the
          // packet completes and the full shutdown runs.
          if (hs && s_axis.tlast) begin
            st    <= HOLD;
            gate  <= 1'b0;
            timer <= disable_dly;
          end
        end

        HOLD: begin
          if (timer == '0) begin
            st              <= GUARD;
            adrv9001_enable <= 1'b0;
            disable_cnt     <= cnt_inc(disable_cnt);
            timer           <= guard_dly;
          end else begin
            timer <= tmr_dec(timer);
          end
        end

        GUARD: begin
          if (timer == '0) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else begin
            timer <= tmr_dec(timer);
          end
        end

        default: begin
          // Illegal encoding: fall back to a clean IDLE, still counting the
          // enable edge if the device was left enabled.
          st    <= IDLE;
          gate  <= 1'b0;
          timer <= '0;
          busy  <= 1'b0;
          if (adrv9001_enable) begin
            adrv9001_enable <= 1'b0;
            disable_cnt     <= cnt_inc(disable_cnt);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adrv9001_enable_seq.sv
`timescale 1ns/1ps
module tb_adrv9001_enable_seq;

  localparam int DLY_W = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             enable_mode = 1'b1;
  logic             sw_en = 1'b0;
  logic             pl_en = 1'b0;
  logic [DLY_W-1:0] enable_dly = 16'd4;
  logic [DLY_W-1:0] disable_dly = 16'd2;
  logic [DLY_W-1:0] guard_dly = 16'd3;
  logic             adrv9001_enable;
  logic [CNT_W-1:0] enable_cnt;
  logic [CNT_W-1:0] disable_cnt;
  logic [2:0]       state;
  logic             busy;

  adrv9001_enable_seq_if s_if ();
  adrv9001_enable_seq_if m_if ();

  adrv9001_enable_seq #(.DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable_mode     (enable_mode),
    .sw_en           (sw_en),
    .pl_en           (pl_en),
    .enable_dly      (enable_dly),
    .disable_dly     (disable_dly),
    .guard_dly       (guard_dly),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .adrv9001_enable (adrv9001_enable),
    .enable_cnt      (enable_cnt),
    .disable_cnt     (disable_cnt),
    .state           (state),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2ns after the falling edge; the monitor samples on the
  // falling edge itself, before any change.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    int n = 0;
    while (state !== 3'(s) && n < lim) begin
      cyc();
      n++;
    end
    chk(nm, 32'(state), 32'(s));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a sequential story of one enable cycle, told with
  // waits on clock edges and loop counts taken straight from the rules
  // (settle = enable_dly+1 edges, hold = disable_dly+1, guard = guard_dly+1).
  // ---------------------------------------------------------------------------
  bit [2:0] m_st;
  bit       m_en, m_gate, m_open, m_req;
  int       m_ecnt, m_dcnt;
  bit       r_m, hs_m, lst_m, ab_m;

  task automatic step();
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      ab_m = 1'b1;
      return;
    end
    r_m   = m_req;
    m_req = enable_mode ? pl_en : sw_en;
    hs_m  = s_if.tvalid && m_if.tready && m_gate;
    lst_m = s_if.tlast;
    if (hs_m) m_open = !lst_m;
  endtask

  task automatic run_seq();
    int d;
    bit aborted;
    forever begin
      m_st = 3'd0;
      m_gate = 1'b0;
      do begin step(); if (ab_m) return; end while (!r_m);
      m_en = 1'b1; m_ecnt++; m_st = 3'd1;
      d = int'(enable_dly);
      aborted = 1'b0;
      for (int k = 0; k <= d; k++) begin
        step(); if (ab_m) return;
        if (!r_m) begin aborted = 1'b1; break; end
      end
      if (!aborted) begin
        m_st = 3'd2; m_gate = 1'b1;
        do begin step(); if (ab_m) return; end while (r_m);
        if (m_open) begin
          m_st = 3'd3;
          do begin step(); if (ab_m) return; end while (!(hs_m && lst_m));
        end
      end
      m_gate = 1'b0; m_st = 3'd4;
      d = int'(disable_dly);
      repeat (d + 1) begin step(); if (ab_m) return; end
      m_en = 1'b0; m_dcnt++; m_st = 3'd5;
      d = int'(guard_dly);
      repeat (d + 1) begin step(); if (ab_m) return; end
    end
  endtask

  initial begin
    forever begin
      m_st = 3'd0; m_en = 1'b0; m_gate = 1'b0; m_open = 1'b0; m_req = 1'b0;
      m_ecnt = 0; m_dcnt = 0; ab_m = 1'b0;
      wait (rstn === 1'b1);
      run_seq();
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rstn) begin
        chk("mon_ctrl", {19'd0, state, busy, adrv9001_enable, enable_cnt, disable_cnt},
            {19'd0, m_st, (m_st != 3'd0), m_en, 4'(m_ecnt), 4'(m_dcnt)});
        chk("mon_gate", {29'd0, m_if.tvalid, s_if.tready, m_if.tlast},
            {29'd0, s_if.tvalid & m_gate, m_if.tready & m_gate, s_if.tlast});
        chk("mon_data", m_if.tdata, s_if.tdata);
      end else begin
        chk("mon_rst", {19'd0, state, busy, adrv9001_enable, enable_cnt, disable_cnt, m_if.tvalid, s_if.tready},
            32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  typedef struct {
    bit          act;
    logic        tv;
    logic        tr;
    logic [31:0] td;
    logic        tl;
    logic        exp_mv;
    logic        exp_sr;
  } gvec_t;

  gvec_t tbl[8];
  int    sq[$];
  int    exp_sq[5] = '{0, 1, 4, 5, 0};

  initial begin
    int fwd, last, g, idl;
    tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h2222_0000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h3333_0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0123_4567, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1};

    s_if.tdata = 32'd0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; m_if.tready = 1'b0;
    mon_en = 1'b1;
    cyc();
    chk("rst_state", {28'd0, state, busy}, 32'd0);
    chk("rst_cnt", {24'd0, enable_cnt, disable_cnt}, 32'd0);
    chk("rst_en", 32'(adrv9001_enable), 32'd0);

    // Gating table with gate closed (held in reset).
    foreach (tbl[i]) if (!tbl[i].act) begin
      s_if.tvalid = tbl[i].tv; m_if.tready = tbl[i].tr; s_if.tdata = tbl[i].td; s_if.tlast = tbl[i].tl;
      #1;
      chk("tbl_off_mv", 32'(m_if.tvalid), 32'(tbl[i].exp_mv));
      chk("tbl_off_sr", 32'(s_if.tready), 32'(tbl[i].exp_sr));
      chk("tbl_off_td", m_if.tdata, tbl[i].td);
      cyc();
    end
    s_if.tvalid = 1'b0; m_if.tready = 1'b0; s_if.tlast = 1'b0;

    // Power-up enable: release reset with pl_en already high.
    rstn = 1'b1; pl_en = 1'b1;
    cyc();
    chk("a_first_edge_idle", {31'd0, adrv9001_enable}, 32'd0);
    cyc();
    chk("a_en_rise", {28'd0, state, adrv9001_enable}, {28'd0, 3'd1, 1'b1});
    chk("a_en_cnt", 32'(enable_cnt), 32'd1);
    s_if.tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("a_settle_gated", 32'(m_if.tvalid), 32'd0);
    end
    cyc();
    chk("a_active", {28'd0, state, m_if.tvalid}, {28'd0, 3'd2, 1'b1});

    // Gating table with gate open.
    foreach (tbl[i]) if (tbl[i].act) begin
      s_if.tvalid = tbl[i].tv; m_if.tready = tbl[i].tr; s_if.tdata = tbl[i].td; s_if.tlast = tbl[i].tl;
      #1;
      chk("tbl_on_mv", 32'(m_if.tvalid), 32'(tbl[i].exp_mv));
      chk("tbl_on_sr", 32'(s_if.tready), 32'(tbl[i].exp_sr));
      chk("tbl_on_tl", 32'(m_if.tlast), 32'(tbl[i].tl));
      cyc();
    end

    // 8-beat packet with the request dropping after beat 3.
    m_if.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 32'hA000 + i; s_if.tlast = (i == 8);
      if (i == 4) pl_en = 1'b0;
      #1;
      chk("b_beat_fwd", {30'd0, m_if.tvalid, s_if.tready}, 32'd3);
      chk("b_beat_data", m_if.tdata, 32'hA000 + i);
      cyc();
    end
    chk("b_hold", {28'd0, state, adrv9001_enable}, {28'd0, 3'd4, 1'b1});
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    cyc(); chk("b_hold_en1", 32'(adrv9001_enable), 32'd1);
    cyc(); chk("b_hold_en2", 32'(adrv9001_enable), 32'd1);
    cyc();
    chk("b_guard", {28'd0, state, adrv9001_enable}, {28'd0, 3'd5, 1'b0});
    chk("b_dis_cnt", 32'(disable_cnt), 32'd1);
    repeat (4) cyc();
    chk("b_idle", {28'd0, state, busy}, 32'd0);

    // Aborted settle: short pulse during a long settle time.
    rstn = 1'b0;
    #1;
    chk("c_async_rst_cnt", {24'd0, enable_cnt, disable_cnt}, 32'd0);
    cyc();
    rstn = 1'b1;
    enable_dly = 16'd10; disable_dly = 16'd2; guard_dly = 16'd3;
    s_if.tvalid = 1'b1; m_if.tready = 1'b1; s_if.tlast = 1'b0;
    pl_en = 1'b1;
    repeat (3) cyc();
    pl_en = 1'b0;
    fwd = 0; last = 0; sq.delete(); sq.push_back(0);
    for (int n = 0; n < 80; n++) begin
      cyc();
      if (m_if.tvalid === 1'b1) fwd++;
      if (int'(state) != last) begin sq.push_back(int'(state)); last = int'(state); end
      if (state == 3'd0 && sq.size() > 1) break;
    end
    chk("c_no_fwd", 32'(fwd), 32'd0);
    chk("c_seq_len", 32'(sq.size()), 32'd5);
    for (int i = 0; i < 5 && i < sq.size(); i++) chk("c_seq_state", 32'(sq[i]), 32'(exp_sq[i]));
    chk("c_cnts", {24'd0, enable_cnt, disable_cnt}, {24'd0, 4'd1, 4'd1});
    s_if.tvalid = 1'b0;

    // Request re-asserted during a long guard time.
    enable_dly = 16'd0; disable_dly = 16'd0; guard_dly = 16'd20;
    pl_en = 1'b1;
    wait_state(2, 20, "d_active");
    pl_en = 1'b0;
    wait_state(5, 20, "d_guard");
    pl_en = 1'b1;
    g = 1; idl = 0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (adrv9001_enable === 1'b1) break;
      if (state == 3'd5) g++;
      else if (state == 3'd0) idl++;
    end
    chk("d_guard_cycles", 32'(g), 32'd21);
    chk("d_idle_cycles", 32'(idl), 32'd1);
    chk("d_reenable", {28'd0, state, adrv9001_enable}, {28'd0, 3'd1, 1'b1});
    pl_en = 1'b0;
    wait_state(0, 80, "d_back_idle");

    // Source select.
    guard_dly = 16'd1;
    enable_mode = 1'b0; pl_en = 1'b1; sw_en = 1'b0;
    repeat (5) cyc();
    chk("e_pl_ignored", 32'(state), 32'd0);
    sw_en = 1'b1;
    cyc(); cyc();
    chk("e_sw_starts", 32'(state), 32'd1);
    sw_en = 1'b0; pl_en = 1'b0;
    wait_state(0, 40, "e_back_idle");

    // Counter wrap and asynchronous reset mid-packet.
    rstn = 1'b0; cyc(); rstn = 1'b1;
    enable_mode = 1'b1; enable_dly = 16'd0; disable_dly = 16'd0; guard_dly = 16'd0;
    for (int i = 0; i < 15; i++) begin
      pl_en = 1'b1; wait_state(1, 10, "f_up");
      pl_en = 1'b0; wait_state(0, 10, "f_down");
    end
    chk("f_all_ones", {24'd0, enable_cnt, disable_cnt}, {24'd0, 4'hF, 4'hF});
    pl_en = 1'b1; wait_state(1, 10, "f_wrap_up");
    chk("f_wrap", 32'(enable_cnt), 32'd0);
    wait_state(2, 10, "f_active");
    m_if.tready = 1'b1; s_if.tvalid = 1'b1; s_if.tlast = 1'b0;
    cyc();
    #1 rstn = 1'b0;
    #1;
    chk("f_rst_async", {22'd0, state, busy, adrv9001_enable, enable_cnt, disable_cnt, m_if.tvalid, s_if.tready},
        32'd0);
    s_if.tvalid = 1'b0; pl_en = 1'b0;
    cyc();
    rstn = 1'b1;

    // Randomised traffic against the model (monitor does the comparing).
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) pl_en = ~pl_en;
      if ($urandom_range(0, 15) == 0) sw_en = ~sw_en;
      if ($urandom_range(0, 63) == 0) enable_mode = ~enable_mode;
      if ($urandom_range(0, 7) == 0) begin
        enable_dly  = 16'($urandom_range(0, 6));
        disable_dly = 16'($urandom_range(0, 6));
        guard_dly   = 16'($urandom_range(0, 6));
      end
      s_if.tvalid  = ($urandom_range(0, 3) != 0);
      s_if.tlast   = ($urandom_range(0, 3) == 0);
      s_if.tdata   = $urandom;
      m_if.tready  = ($urandom_range(0, 3) != 0);
      if (n == 1500) begin
        rstn = 1'b0; cyc(); rstn = 1'b1;
      end
      cyc();
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
